// File: rtl/mlp_stage_sequencer.sv
// mlp_stage_sequencer: runs the HD -> HR -> OD -> OR layer engines via start/done handshakes, then argmaxes the scores.
// Define MLP_SEQ_TIMEOUT_EN to add a per-stage watchdog that aborts to FIN with error=1 and predict_digit=4'hF.
module mlp_stage_sequencer #(
    parameter int OL_NEURONS = 10,
    parameter int SCORE_W    = 32
`ifdef MLP_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      start,
    output logic                      hd_start,
    input  logic                      hd_done,
    output logic                      hr_start,
    input  logic                      hr_done,
    output logic                      od_start,
    input  logic                      od_done,
    output logic                      or_start,
    input  logic                      or_done,
    output logic [3:0]                score_idx,
    input  logic signed [SCORE_W-1:0] score_in,
    output logic [3:0]                predict_digit,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    typedef enum logic [2:0] {S_IDLE, S_HD, S_HR, S_OD, S_OR, S_ARGMAX, S_FIN} state_t;
    localparam logic [3:0] LAST = 4'(OL_NEURONS - 1);

    state_t                    state, state_nx;
    logic                      entry, entry_nx;
    logic [3:0]                idx, idx_nx, best_idx, best_idx_nx, predict_nx;
    logic signed [SCORE_W-1:0] best_score, best_score_nx;
    logic                      stage_done, better, timeout;

    // entry marks the first cycle of a stage; it drives the start pulse and masks stale done levels
    assign stage_done = (state == S_HD && hd_done) || (state == S_HR && hr_done) ||
                        (state == S_OD && od_done) || (state == S_OR && or_done);
    assign better     = idx == 4'd0 || score_in > best_score;
    assign hd_start   = state == S_HD && entry;
    assign hr_start   = state == S_HR && entry;
    assign od_start   = state == S_OD && entry;
    assign or_start   = state == S_OR && entry;
    assign score_idx  = idx;
    assign busy       = state != S_IDLE;
    assign done       = state == S_FIN;

`ifdef MLP_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer;
    logic          error_q, error_nx;
    assign timeout  = timer == TW'(TIMEOUT_CYCLES - 1);
    assign error    = error_q;
    assign error_nx = state == S_IDLE && start ? 1'b0 :
                      state != S_ARGMAX && state_nx == S_FIN ? 1'b1 : error_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            timer   <= '0;
            error_q <= 1'b0;
        end else if (en) begin
            timer   <= entry_nx ? '0 : timer + 1'b1;
            error_q <= error_nx;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        entry_nx      = 1'b0;
        idx_nx        = idx;
        best_idx_nx   = best_idx;
        best_score_nx = best_score;
        predict_nx    = predict_digit;
        case (state)
            S_IDLE: if (start) begin
                state_nx = S_HD;
                entry_nx = 1'b1;
            end
            S_HD, S_HR, S_OD, S_OR: begin
                if (!entry && stage_done) begin
                    state_nx = state_t'(state + 3'd1);
                    entry_nx = state != S_OR;
                end else if (timeout) begin
                    state_nx   = S_FIN;
                    predict_nx = 4'hF;
                end
            end
            S_ARGMAX: begin
                best_idx_nx   = better ? idx : best_idx;
                best_score_nx = better ? score_in : best_score;
                idx_nx        = idx == LAST ? 4'd0 : idx + 4'd1;
                state_nx      = idx == LAST ? S_FIN : S_ARGMAX;
                predict_nx    = idx == LAST ? best_idx_nx : predict_digit;
            end
            S_FIN: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            entry         <= 1'b0;
            idx           <= 4'd0;
            best_idx      <= 4'd0;
            best_score    <= '0;
            predict_digit <= 4'd0;
        end else if (en) begin
            state         <= state_nx;
            entry         <= entry_nx;
            idx           <= idx_nx;
            best_idx      <= best_idx_nx;
            best_score    <= best_score_nx;
            predict_digit <= predict_nx;
        end
    end
endmodule

// File: tb/tb_mlp_stage_sequencer.sv
// tb_mlp_stage_sequencer: randomized scoreboard bench; engine models answer start pulses, a monitor checks every done.
module tb_mlp_stage_sequencer;
    localparam int N  = 10;
    localparam int TO = 20;
    localparam int S1 [10] = '{3, -2, 0, 9, 4, 9, 1, 0, 0, -7};
    typedef struct { int digit; int cyc; int err; } exp_t;

    logic               clk = 1'b0, reset = 1'b1, en = 1'b1, start = 1'b0;
    logic               hd_start, hr_start, od_start, or_start;
    logic               hd_done = 1'b0, hr_done = 1'b0, od_done = 1'b0, or_done = 1'b0;
    logic [3:0]         score_idx, predict_digit;
    logic signed [31:0] score_in;
    logic               busy, done, error;

    int   scores [16];
    int   dly [4];
    int   st_cyc [4];
    int   cnt [4];
    bit   arm [4];
    bit   dn [4];
    bit   tied_hd = 1'b0, od_never = 1'b0;
    int   cyc = 0, exp_next = 0, checks = 0, errors = 0;
    logic [3:0] eng_sv, mon_sv, psv;
    bit   pdone;
    exp_t it;
    exp_t sb [$];

    assign score_in = scores[score_idx];
    always #5 clk = ~clk;

    mlp_stage_sequencer #(
        .OL_NEURONS(N), .SCORE_W(32)
`ifdef MLP_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk(clk), .reset(reset), .en(en), .start(start),
        .hd_start(hd_start), .hd_done(hd_done), .hr_start(hr_start), .hr_done(hr_done),
        .od_start(od_start), .od_done(od_done), .or_start(or_start), .or_done(or_done),
        .score_idx(score_idx), .score_in(score_in), .predict_digit(predict_digit),
        .busy(busy), .done(done), .error(error)
    );

    function automatic void chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < N; i++) if (scores[i] > scores[best]) best = i;
        return best;
    endfunction

    // engines: each answers its start with done after dly enabled cycles
    initial forever begin
        @(posedge clk); #1;
        eng_sv = {or_start, od_start, hr_start, hd_start};
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                arm[k] = 1'b0;
                dn[k]  = 1'b0;
            end else if (eng_sv[k]) begin
                cnt[k] = dly[k];
                arm[k] = 1'b1;
                dn[k]  = 1'b0;
            end else if (en && arm[k]) begin
                cnt[k]--;
                dn[k] = cnt[k] == 0;
                if (dn[k]) arm[k] = 1'b0;
            end else if (en) dn[k] = 1'b0;
        end
        hd_done = tied_hd | dn[0];
        hr_done = dn[1];
        od_done = dn[2] & !od_never;
        or_done = dn[3];
    end

    // monitor: start pulse order/width, and scoreboard pop on each done pulse
    initial begin
        psv   = '0;
        pdone = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            mon_sv = {or_start, od_start, hr_start, hd_start};
            if (reset) begin
                exp_next = 0;
                psv      = '0;
                pdone    = 1'b0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (psv[k] && en) chk(!mon_sv[k], "start_width", int'(mon_sv[k]), 0);
                    if (mon_sv[k] && !psv[k]) begin
                        chk(k == exp_next, "start_order", k, exp_next);
                        exp_next  = k + 1;
                        st_cyc[k] = cyc;
                    end
                end
                if (pdone && en) chk(!done && !busy, "after_done", int'({done, busy}), 0);
                if (done && !(pdone && !en)) begin
                    if (sb.size() == 0) chk(1'b0, "unexpected_done", 1, 0);
                    else begin
                        it = sb.pop_front();
                        chk(int'(predict_digit) == it.digit, "predict_digit", int'(predict_digit), it.digit);
                        chk(cyc == it.cyc, "done_cycle", cyc, it.cyc);
                        chk(int'(error) == it.err, "error_at_done", int'(error), it.err);
                    end
                    exp_next = 0;
                end
                psv   = mon_sv;
                pdone = done;
            end
        end
    end

    task automatic issue(input int extra);
        exp_t e;
        int   t;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t       = cyc + extra;
        e.err   = 0;
        e.digit = ref_argmax();
        for (int k = 0; k < 4; k++) begin
            if (k == 2 && od_never) begin
                t       += TO;
                e.digit  = 15;
                e.err    = 1;
                break;
            end
            t += 1 + ((k == 0 && tied_hd) ? 1 : dly[k]);
        end
        if (e.err == 0) t += N;
        e.cyc = t;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 400) begin @(negedge clk); t++; end
        chk(sb.size() == 0, name, sb.size(), 0);
    endtask

    task automatic wait_stage(input int k, input string name);
        int t = 0;
        logic [3:0] v;
        v = {or_start, od_start, hr_start, hd_start};
        while (!v[k] && t < 200) begin
            @(negedge clk);
            t++;
            v = {or_start, od_start, hr_start, hd_start};
        end
        chk(v[k], name, int'(v[k]), 1);
    endtask

    task automatic load_s1();
        for (int i = 0; i < 16; i++) scores[i] = i < N ? S1[i] : 0;
    endtask

    initial begin
        int t;
        for (int i = 0; i < 16; i++) scores[i] = 0;
        for (int k = 0; k < 4; k++) dly[k] = 5;
        repeat (3) @(negedge clk);
        chk({busy, done, error, hd_start, hr_start, od_start, or_start} == 7'd0, "reset_ctrl",
            int'({busy, done, error, hd_start, hr_start, od_start, or_start}), 0);
        chk(predict_digit == 4'd0, "reset_predict", int'(predict_digit), 0);
        chk(score_idx == 4'd0, "reset_score_idx", int'(score_idx), 0);
        reset = 1'b0;
        load_s1();
        issue(0);
        wait_idle("t1_run");
        repeat (3) @(negedge clk);
        chk(predict_digit == 4'd3 && !busy, "t1_hold", int'(predict_digit), 3);
        for (int i = 0; i < 16; i++) scores[i] = -5;
        issue(0);
        wait_idle("t2_ties");
        for (int i = 0; i < 16; i++) scores[i] = int'($urandom_range(0, 50)) - 50;
        scores[9] = 100;
        issue(0);
        wait_idle("t2_max9");
        load_s1();
        issue(0);
        wait_stage(2, "t3_od");
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle("t3_run");
        issue(0);
        wait_idle("t3_rerun");
        issue(0);
        wait_stage(1, "t4_hr");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk({busy, done, hd_start, hr_start, od_start, or_start} == 6'd0, "t4_ctrl",
            int'({busy, done, hd_start, hr_start, od_start, or_start}), 0);
        chk(predict_digit == 4'd0, "t4_predict", int'(predict_digit), 0);
        sb.delete();
        reset = 1'b0;
        issue(0);
        wait_idle("t4_clean");
        issue(7);
        wait_stage(2, "t5_od");
        en = 1'b0;
        repeat (7) @(negedge clk);
        en = 1'b1;
        wait_idle("t5_od_stall");
        issue(7);
        t = 0;
        while (score_idx != 4'd3 && t < 200) begin @(negedge clk); t++; end
        chk(score_idx == 4'd3, "t5_argmax", int'(score_idx), 3);
        en = 1'b0;
        repeat (7) @(negedge clk);
        en = 1'b1;
        wait_idle("t5_argmax_stall");
        tied_hd = 1'b1;
        issue(0);
        wait_idle("t5_tied");
        chk(st_cyc[1] - st_cyc[0] == 2, "t5_hd_len", st_cyc[1] - st_cyc[0], 2);
        tied_hd = 1'b0;
        repeat (8) begin
            for (int k = 0; k < 4; k++) dly[k] = int'($urandom_range(1, 6));
            for (int i = 0; i < 16; i++) scores[i] = int'($urandom_range(0, 12)) - 6;
            issue(0);
            wait_idle("rand_run");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
`ifdef MLP_SEQ_TIMEOUT_EN
        for (int k = 0; k < 4; k++) dly[k] = 5;
        od_never = 1'b1;
        issue(0);
        wait_idle("t6_timeout");
        repeat (2) @(negedge clk);
        chk(error, "t6_sticky", int'(error), 1);
        od_never = 1'b0;
        issue(0);
        chk(!error, "t6_clear", int'(error), 0);
        wait_idle("t6_rerun");
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
